median_filter_scalable_core: RTL and testbench
==============================================

MEDIAN_FILTER_SCALABLE_CORE -- requirements
Module: median_filter_scalable

Interface
REQ-001 The block SHALL have parameter SIZE, default 100, giving the pixels per input row (legal range SIZE >= 3).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port arr_in, input, unpacked array [SIZE-1:0] of 8 bits: one image row per clock, element c = pixel column c.
REQ-005 The block SHALL have port arr_out, output, unpacked array [SIZE-3:0] of 8 bits: one filtered row, element c = median of the 3x3 window over input columns c..c+2.

Function
REQ-006 The block SHALL accept a new row on every rising edge of clk; there is no valid or handshake signal, and the row stream is continuous.
REQ-007 The block SHALL keep a 3-row window (oldest, middle, newest); on each edge it shifts middle->oldest, newest->middle, arr_in->newest.
REQ-008 Window rows r, r+1, r+2 SHALL be complete on the edge that captures row r+2 (edge n), and SHALL produce output row r.
REQ-009 Output row r SHALL be visible on arr_out immediately after edge n+5 (fixed latency of 5 edges from capture of the window's last row).
- Staging inside the 5 cycles is free (for example: column 3-sort, then max-of-mins / median-of-mids / min-of-maxes, then median-of-3, then output register).
- The latency SHALL be exact and identical for all columns.
REQ-010 The block SHALL fully pipeline the filter: one output row per clock, with successive window rows producing successive output rows on successive edges.
REQ-011 arr_out[c] SHALL equal the exact median (5th smallest) of the 9 unsigned 8-bit pixels in rows r..r+2 and columns c..c+2; ties are resolved by value, so duplicates count individually.
REQ-012 Comparisons SHALL be unsigned 8-bit and the output SHALL be a selected input value, never arithmetic-derived.
REQ-013 The block SHALL produce no border output: the edge columns and rows are dropped, so an SxS image yields (S-2)x(S-2).
REQ-014 The block SHALL provide an output on every edge, including windows containing reset-cleared rows; the consumer discards the first 2+5 output cycles after reset.
REQ-015 The SIZE-2 column units SHALL be generated by parameter, with no fixed-size hardcoding; the datapath width is fixed at 8 bits.

Reset
REQ-016 When rst is asserted, the block SHALL immediately (asynchronously) clear all window rows, all pipeline registers and arr_out to 0.
REQ-017 While rst is high, the block SHALL ignore arr_in; the first edge with rst low SHALL capture arr_in as the newest row.
REQ-018 Reset asserted mid-stream SHALL discard all in-flight rows, and no pre-reset data SHALL appear on arr_out afterward.

Verification
REQ-019 Constant-image test: rows all 8'h80 for 10 edges after reset -> arr_out all 8'h80 from edge 2+5 onward.
REQ-020 Salt-noise test: SIZE=5, all pixels 8'h40 except a single 8'hFF at (row 2, col 2) -> every arr_out element is 8'h40, so the impulse is removed.
REQ-021 Ordered-window test: SIZE=3, rows {1,2,3},{4,5,6},{7,8,9} -> arr_out[0]=5 exactly 5 edges after row 3 is captured.
REQ-022 Latency/streaming test: SIZE=100, 100 rows of a ramp image (pixel = row+col, saturated at 255) -> 98 output rows on consecutive edges starting 5 edges after row 2 is captured, each matching a software 3x3 median.
REQ-023 Reset mid-operation test: assert rst after row 50 -> arr_out reads 0 immediately, and after release arr_out shows 0 until new windows propagate (7 edges).

Source files
------------

// File: rtl/median_filter_scalable_core.sv
// Streaming 3x3 median filter: one SIZE-pixel row in, one (SIZE-2)-pixel
// filtered row out per clock, fixed 5-edge latency from the window's last row.

module median_filter_lane (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0][7:0] lo,
  input  logic [2:0][7:0] md,
  input  logic [2:0][7:0] hi,
  output logic [7:0]      y
);
  function automatic logic [7:0] mn(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return mx(mn(a, b), mn(mx(a, b), c));
  endfunction

  logic [7:0] max_lo, med_md, min_hi, med, med_d;

  // With every column already sorted, the 9-pixel median is the median of
  // (largest column-min, median column-mid, smallest column-max).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_lo <= '0;
      med_md <= '0;
      min_hi <= '0;
      med    <= '0;
      med_d  <= '0;
      y      <= '0;
    end else begin
      max_lo <= mx(mx(lo[0], lo[1]), lo[2]);
      med_md <= med3(md[0], md[1], md[2]);
      min_hi <= mn(mn(hi[0], hi[1]), hi[2]);
      med    <= med3(max_lo, med_md, min_hi);
      med_d  <= med;
      y      <= med_d;
    end
  end
endmodule

module median_filter_scalable_core #(
  parameter int SIZE = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] arr_in  [SIZE-1:0],
  output logic [7:0] arr_out [SIZE-3:0]
);
  function automatic logic [7:0] mn(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? b : a;
  endfunction

  logic [7:0] win_old [SIZE];
  logic [7:0] win_mid [SIZE];
  logic [7:0] win_new [SIZE];
  logic [7:0] s_lo    [SIZE];
  logic [7:0] s_md    [SIZE];
  logic [7:0] s_hi    [SIZE];

  // Row window shift plus per-column 3-sort; the sort is shared by the
  // three output lanes that overlap each input column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        win_old[i] <= '0;
        win_mid[i] <= '0;
        win_new[i] <= '0;
        s_lo[i]    <= '0;
        s_md[i]    <= '0;
        s_hi[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        win_old[i] <= win_mid[i];
        win_mid[i] <= win_new[i];
        win_new[i] <= arr_in[i];
        s_lo[i]    <= mn(mn(win_old[i], win_mid[i]), win_new[i]);
        s_md[i]    <= mx(mn(win_old[i], win_mid[i]),
                         mn(mx(win_old[i], win_mid[i]), win_new[i]));
        s_hi[i]    <= mx(mx(win_old[i], win_mid[i]), win_new[i]);
      end
    end
  end

  for (genvar c = 0; c < SIZE - 2; c++) begin : g_lane
    median_filter_lane u_lane (
      .clk (clk),
      .rst (rst),
      .lo  ({s_lo[c+2], s_lo[c+1], s_lo[c]}),
      .md  ({s_md[c+2], s_md[c+1], s_md[c]}),
      .hi  ({s_hi[c+2], s_hi[c+1], s_hi[c]}),
      .y   (arr_out[c])
    );
  end
endmodule

// File: tb/tb_median_filter_scalable_core.sv
// Scoreboard bench for median_filter_scalable_core: the driver pushes the
// expected output row with its due cycle; a negedge monitor pops and compares.

module tb_median_filter_scalable_core;
  localparam int SIZE = 100;
  localparam int OW   = SIZE - 2;

  typedef logic [7:0] row_t [SIZE];
  typedef struct packed {
    int                   due;
    int                   kind;
    int                   hv;
    logic [OW-1:0][7:0]   v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] arr_in  [SIZE-1:0];
  logic [7:0] arr_out [SIZE-3:0];

  row_t m0, m1, m2;
  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  median_filter_scalable_core #(.SIZE(SIZE)) dut (
    .clk     (clk),
    .rst     (rst),
    .arr_in  (arr_in),
    .arr_out (arr_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] med9(input row_t a, input row_t b, input row_t c,
                                      input int col);
    logic [7:0] s [9];
    logic [7:0] t;
    for (int k = 0; k < 3; k++) begin
      s[k]   = a[col+k];
      s[k+3] = b[col+k];
      s[k+6] = c[col+k];
    end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[4];
  endfunction

  task automatic drive(input row_t r, input int kind, input int hv);
    exp_t e;
    for (int c = 0; c < SIZE; c++) arr_in[c] = r[c];
    m0 = m1; m1 = m2; m2 = r;
    e.due  = cyc + 6;
    e.kind = kind;
    e.hv   = hv;
    for (int c = 0; c < OW; c++) e.v[c] = med9(m0, m1, m2, c);
    q.push_back(e);
  endtask

  task automatic step(input row_t r, input int kind, input int hv);
    @(negedge clk);
    drive(r, kind, hv);
  endtask

  task automatic check_zero(input string nm);
    int bad;
    bad = -1;
    for (int c = 0; c < OW; c++) if (arr_out[c] !== 8'h00 && bad < 0) bad = c;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: arr_out[%0d] got %h want 00", nm, bad, arr_out[bad]);
    end
  endtask

  // Reset asserts between edges; after release the pipeline flushes zeros
  // for 5 edges, then windows containing reset-cleared rows appear.
  task automatic do_reset(input string nm);
    exp_t e;
    row_t z;
    for (int c = 0; c < SIZE; c++) z[c] = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    m0 = z; m1 = z; m2 = z;
    #1 check_zero(nm);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      e.due = cyc + k; e.kind = 0; e.hv = 0;
      for (int c = 0; c < OW; c++) e.v[c] = 8'h00;
      q.push_back(e);
    end
    drive(z, 0, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   bad;
    int   w;
    if (!rst) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        n_chk++;
        if (e.due != cyc) begin
          n_fail++;
          $display("FAIL sb_missed: due %0d seen at cycle %0d", e.due, cyc);
        end else begin
          bad = -1;
          for (int c = 0; c < OW; c++) if (arr_out[c] !== e.v[c] && bad < 0) bad = c;
          if (bad >= 0) begin
            n_fail++;
            $display("FAIL sb_row cyc %0d: arr_out[%0d] got %h want %h",
                     cyc, bad, arr_out[bad], e.v[bad]);
          end
          if (e.kind != 0) begin
            n_chk++;
            bad = -1;
            for (int c = 0; c < OW; c++) begin
              if (e.kind == 1)      w = e.hv;
              else if (e.kind == 3) w = (e.hv + c + 2 > 255) ? 255 : e.hv + c + 2;
              else                  w = (c == 0) ? e.hv : int'(arr_out[c]);
              if (int'(arr_out[c]) != w && bad < 0) bad = c;
            end
            if (bad >= 0) begin
              n_fail++;
              $display("FAIL hand_kind%0d cyc %0d: arr_out[%0d] got %h", e.kind, cyc,
                       bad, arr_out[bad]);
            end
          end
        end
      end
    end
  end

  initial begin
    row_t r;
    for (int c = 0; c < SIZE; c++) arr_in[c] = 8'h00;
    #2 rst = 1'b1;
    #1 check_zero("reset_initial");
    do_reset("reset_start");

    for (int i = 0; i < 10; i++) begin          // constant image
      for (int c = 0; c < SIZE; c++) r[c] = 8'h80;
      step(r, (i >= 2) ? 1 : 0, 8'h80);
    end
    for (int i = 0; i < 5; i++) begin           // salt impulse at row 2 col 2
      for (int c = 0; c < SIZE; c++) r[c] = 8'h40;
      if (i == 2) r[2] = 8'hFF;
      step(r, (i >= 2) ? 1 : 0, 8'h40);
    end
    for (int i = 0; i < 3; i++) begin           // ordered 1..9 window in cols 0..2
      for (int c = 0; c < SIZE; c++) r[c] = 8'h00;
      for (int c = 0; c < 3; c++) r[c] = 8'(3 * i + c + 1);
      step(r, (i == 2) ? 2 : 0, 5);
    end
    for (int i = 0; i < 100; i++) begin         // full saturated ramp
      for (int c = 0; c < SIZE; c++) r[c] = (i + c > 255) ? 8'hFF : 8'(i + c);
      step(r, (i >= 2) ? 3 : 0, i - 2);
    end
    for (int i = 0; i < 50; i++) begin          // ramp cut by reset
      for (int c = 0; c < SIZE; c++) r[c] = (i + c > 255) ? 8'hFF : 8'(i + c);
      step(r, (i >= 2) ? 3 : 0, i - 2);
    end
    do_reset("reset_midstream");
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < SIZE; c++) r[c] = 8'h80;
      step(r, (i >= 2) ? 1 : 0, 8'h80);
    end

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d rows pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
